// File: rtl/cache_refill_ctrl.sv
// Sequencer between the CPU and the cache array: read lookup, refill on miss,
// write-through on writes, saturating hit/miss statistics.
module cache_refill_ctrl #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int CNT_W       = 32,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic              cpu_resp_valid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_err,
  output logic [ADDR_W-1:0] cache_addr,
  output logic [DATA_W-1:0] cache_wdata,
  output logic              cache_we,
  output logic              cache_re,
  input  logic [DATA_W-1:0] cache_rdata,
  input  logic              cache_hit,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              stat_clr,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count
);

  typedef enum logic [2:0] {
    IDLE, LOOKUP, CHECK, MEM_RD, MEM_WR, FILL, RESP
  } state_t;

  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

  state_t            state, state_n;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] fill_q;
  logic [TW-1:0]     wait_cnt;
  logic              mem_wait;
  logic              timeout;

  assign mem_wait = (state == MEM_RD) || (state == MEM_WR);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n        = state;
    timeout        = 1'b0;
    cpu_ready      = 1'b0;
    cpu_resp_valid = 1'b0;
    cache_re       = 1'b0;
    cache_we       = 1'b0;
    mem_req        = 1'b0;
    mem_we         = 1'b0;
    case (state)
      IDLE: begin
        cpu_ready = 1'b1;
        if (cpu_req) state_n = cpu_we ? MEM_WR : LOOKUP;
      end
      LOOKUP: begin
        cache_re = 1'b1;
        state_n  = CHECK;
      end
      CHECK: state_n = cache_hit ? RESP : MEM_RD;
      MEM_RD, MEM_WR: begin
        mem_req = 1'b1;
        mem_we  = (state == MEM_WR);
        // An ack arriving on the final wait cycle still completes normally.
        if (mem_ack) state_n = FILL;
        else if (TIMEOUT_CYC != 0 && wait_cnt == TO_LAST) begin
          timeout = 1'b1;
          state_n = RESP;
        end
      end
      FILL: begin
        cache_we = 1'b1;
        state_n  = RESP;
      end
      RESP: begin
        cpu_resp_valid = 1'b1;
        state_n        = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      fill_q    <= '0;
      wait_cnt  <= '0;
      cpu_rdata <= '0;
      cpu_err   <= 1'b0;
    end else begin
      if (state == IDLE && cpu_req) begin
        addr_q  <= cpu_addr;
        wdata_q <= cpu_wdata;
      end
      wait_cnt <= mem_wait ? wait_cnt + 1'b1 : '0;
      if (state == CHECK && cache_hit) begin
        cpu_rdata <= cache_rdata;
        cpu_err   <= 1'b0;
      end
      if (mem_wait && mem_ack) begin
        fill_q  <= (state == MEM_RD) ? mem_rdata : wdata_q;
        cpu_err <= 1'b0;
        if (state == MEM_RD) cpu_rdata <= mem_rdata;
      end else if (timeout) begin
        cpu_rdata <= '0;
        cpu_err   <= 1'b1;
      end
    end
  end

  // Clear wins over a same-cycle increment; counts stick at all-ones.
  always_ff @(posedge clk) begin
    if (reset || stat_clr) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (state == CHECK) begin
      if (cache_hit && !(&hit_count))    hit_count  <= hit_count + 1'b1;
      if (!cache_hit && !(&miss_count))  miss_count <= miss_count + 1'b1;
    end
  end

  assign cache_addr  = addr_q;
  assign cache_wdata = fill_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Directed bench for cache_refill_ctrl: hit, miss refill, write-through,
// timeout, ack on the last wait cycle, mid-transaction reset, counter saturation.
module tb_cache_refill_ctrl;
  localparam int AW = 32, DW = 32, CW = 4, TO = 8;

  logic          clk = 1'b0, reset = 1'b1;
  logic          cpu_req = 0, cpu_we = 0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          cpu_ready, cpu_resp_valid, cpu_err;
  logic [DW-1:0] cpu_rdata;
  logic [AW-1:0] cache_addr;
  logic [DW-1:0] cache_wdata;
  logic          cache_we, cache_re;
  logic [DW-1:0] cache_rdata = '0;
  logic          cache_hit = 0;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack = 0;
  logic [DW-1:0] mem_rdata = '0;
  logic          stat_clr = 0;
  logic [CW-1:0] hit_count, miss_count;

  int n_chk = 0, n_fail = 0, n_we = 0, n_we0;

  cache_refill_ctrl #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW), .TIMEOUT_CYC(TO)) u_dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_resp_valid(cpu_resp_valid), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
    .cache_addr(cache_addr), .cache_wdata(cache_wdata), .cache_we(cache_we), .cache_re(cache_re),
    .cache_rdata(cache_rdata), .cache_hit(cache_hit),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .stat_clr(stat_clr), .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (cache_we) n_we <= n_we + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic accept(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    cpu_req = 1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    chk("ready_before_accept", 32'(cpu_ready), 1);
    tick();
    cpu_req = 0;
  endtask

  // Full hit transaction; clr asserts stat_clr during CHECK. Ends back in IDLE.
  task automatic read_hit(input logic [AW-1:0] addr, input logic [DW-1:0] d, input logic clr);
    accept(0, addr, '0);
    cache_hit = 1; cache_rdata = d;
    tick();
    stat_clr = clr;
    tick();
    stat_clr = 0;
    chk("hit_resp", 32'(cpu_resp_valid), 1);
    chk("hit_rdata", cpu_rdata, d);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(); tick();
    chk("rst_ready", 32'(cpu_ready), 1);
    chk("rst_resp", 32'(cpu_resp_valid), 0);
    chk("rst_rdata", cpu_rdata, 0);
    chk("rst_err", 32'(cpu_err), 0);
    chk("rst_memreq", 32'(mem_req), 0);
    chk("rst_cache_strobes", {30'd0, cache_we, cache_re}, 0);
    chk("rst_counts", {24'd0, hit_count, miss_count}, 0);
    chk("rst_addr", cache_addr | mem_addr, 0);
    reset = 0;

    // Read hit; cpu_req stays high and a stray mem_ack arrives while busy.
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h100;
    tick();
    cpu_we = 1; mem_ack = 1;
    chk("t1_lookup_re", 32'(cache_re), 1);
    chk("t1_lookup_addr", cache_addr, 32'h100);
    chk("t1_busy_ready", 32'(cpu_ready), 0);
    cache_hit = 1; cache_rdata = 32'hCAFE;
    tick();
    mem_ack = 0;
    chk("t1_resp_early", 32'(cpu_resp_valid), 0);
    tick();
    chk("t1_resp_at_3", 32'(cpu_resp_valid), 1);
    chk("t1_rdata", cpu_rdata, 32'hCAFE);
    chk("t1_err", 32'(cpu_err), 0);
    chk("t1_hits", 32'(hit_count), 1);
    chk("t1_no_memreq", 32'(mem_req), 0);
    cpu_req = 0;
    tick();
    chk("t1_idle", {30'd0, cpu_ready, cpu_resp_valid}, 2);
    chk("t1_ignored_req", 32'(mem_req), 0);

    // Read miss, ack on the 5th mem_req cycle.
    accept(0, 32'h200, '0);
    cache_hit = 0;
    tick(); tick();
    chk("t2_memreq", {30'd0, mem_req, mem_we}, 2);
    chk("t2_memaddr", mem_addr, 32'h200);
    chk("t2_miss", 32'(miss_count), 1);
    repeat (4) tick();
    chk("t2_memreq_held", 32'(mem_req), 1);
    mem_ack = 1; mem_rdata = 32'h1234; n_we0 = n_we;
    tick();
    mem_ack = 0;
    chk("t2_fill_we", 32'(cache_we), 1);
    chk("t2_fill_addr", cache_addr, 32'h200);
    chk("t2_fill_data", cache_wdata, 32'h1234);
    chk("t2_memreq_drop", 32'(mem_req), 0);
    tick();
    chk("t2_resp", 32'(cpu_resp_valid), 1);
    chk("t2_rdata", cpu_rdata, 32'h1234);
    chk("t2_one_fill", 32'(n_we - n_we0), 1);
    tick();

    // Write-through; ack on the final permitted wait cycle still completes.
    accept(1, 32'h300, 32'hBEEF);
    chk("t3_memreq", {30'd0, mem_req, mem_we}, 3);
    chk("t3_memaddr", mem_addr, 32'h300);
    chk("t3_memwdata", mem_wdata, 32'hBEEF);
    repeat (TO - 1) tick();
    chk("t3_memreq_last", 32'(mem_req), 1);
    mem_ack = 1; n_we0 = n_we;
    tick();
    mem_ack = 0;
    chk("t3_fill_we", 32'(cache_we), 1);
    chk("t3_fill_data", cache_wdata, 32'hBEEF);
    chk("t3_fill_addr", cache_addr, 32'h300);
    tick();
    chk("t3_resp", 32'(cpu_resp_valid), 1);
    chk("t3_err", 32'(cpu_err), 0);
    chk("t3_rdata_held", cpu_rdata, 32'h1234);
    chk("t3_counts", {24'd0, hit_count, miss_count}, 32'h11);
    chk("t3_one_fill", 32'(n_we - n_we0), 1);
    tick();

    // Read miss with no ack: times out after TO wait cycles.
    accept(0, 32'h400, '0);
    cache_hit = 0;
    tick(); tick();
    n_we0 = n_we;
    repeat (TO - 1) tick();
    chk("t4_memreq_last", 32'(mem_req), 1);
    tick();
    chk("t4_memreq_drop", 32'(mem_req), 0);
    chk("t4_resp", 32'(cpu_resp_valid), 1);
    chk("t4_err", 32'(cpu_err), 1);
    chk("t4_rdata", cpu_rdata, 0);
    chk("t4_no_fill", 32'(n_we - n_we0), 0);
    tick();
    chk("t4_idle", 32'(cpu_ready), 1);

    // Reset during MEM_RD aborts with no response.
    accept(0, 32'h500, '0);
    tick(); tick();
    chk("t5_memreq", 32'(mem_req), 1);
    tick();
    reset = 1;
    tick();
    reset = 0;
    chk("t5_memreq_low", 32'(mem_req), 0);
    chk("t5_ready", 32'(cpu_ready), 1);
    chk("t5_no_resp", 32'(cpu_resp_valid), 0);
    chk("t5_counts", {24'd0, hit_count, miss_count}, 0);
    tick();
    chk("t5_no_resp_late", 32'(cpu_resp_valid), 0);

    // Saturation and clear priority.
    for (int i = 0; i < 15; i++) read_hit(32'h600 + 32'(i), 32'hA000 + 32'(i), 0);
    chk("t6_hits_full", 32'(hit_count), 15);
    read_hit(32'h700, 32'h5A5A, 0);
    chk("t6_hits_sat", 32'(hit_count), 15);
    read_hit(32'h704, 32'h0F0F, 1);
    chk("t6_hits_clr", 32'(hit_count), 0);
    chk("t6_miss_clr", 32'(miss_count), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
